// File: rtl/max7219_pkg.sv
// ---------------------------------------------------------------------------
// max7219_pkg
// Shared definitions for the MAX7219 settings sequencer:
//   - fixed MAX7219 register addresses
//   - sequencer state encoding
//   - latched request and command-entry structures
//   - the command list, expressed as a lookup function indexed by entry number
// ---------------------------------------------------------------------------
package max7219_pkg;

  // MAX7219 register map (digit registers are DIGIT0 .. DIGIT0+7)
  localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] ADDR_DECODE     = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
  localparam logic [3:0] ADDR_TEST       = 4'hF;

  // Number of register writes in a configuration sequence
  localparam int unsigned CFG_COUNT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Everything captured from the input ports when a request is accepted
  typedef struct packed {
    logic       write_config;
    logic [2:0] digit;
    logic [7:0] segment;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       enable;
    logic       display_test;
  } req_t;

  // One addr/data transaction handed to the serial driver
  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  // Command list: a digit write has a single entry, a configuration write has
  // CFG_COUNT entries issued in the fixed order below.
  function automatic cmd_t cmd_entry(input req_t req, input logic [2:0] idx);
    cmd_t cmd;
    cmd = '0;
    if (!req.write_config) begin
      cmd.addr = ADDR_DIGIT0 + {1'b0, req.digit};
      cmd.data = req.segment;
    end else begin
      case (idx)
        3'd0:    begin cmd.addr = ADDR_DECODE;     cmd.data = req.decode_mode;             end
        3'd1:    begin cmd.addr = ADDR_INTENSITY;  cmd.data = {4'h0, req.intensity};       end
        3'd2:    begin cmd.addr = ADDR_SCAN_LIMIT; cmd.data = {5'h00, req.scan_limit};     end
        3'd3:    begin cmd.addr = ADDR_SHUTDOWN;   cmd.data = {7'h00, req.enable};         end
        3'd4:    begin cmd.addr = ADDR_TEST;       cmd.data = {7'h00, req.display_test};   end
        default: cmd = '0;
      endcase
    end
    return cmd;
  endfunction

  // True when idx is the final entry of the request's command list
  function automatic logic is_last(input req_t req, input logic [2:0] idx);
    return !req.write_config || (idx == 3'(CFG_COUNT - 1));
  endfunction

endpackage

// File: rtl/max7219_settings_ctrl.sv
// ---------------------------------------------------------------------------
// max7219_settings_ctrl
// Sequences register writes toward the MAX7219 serial driver. A strobe either
// writes one digit register or the full configuration set (decode mode,
// intensity, scan limit, shutdown, display test). Each write is issued as a
// one-cycle o_write with o_addr/o_data, then the block waits for the driver's
// i_next before issuing the next entry or finishing.
//
// Ports
//   i_clk, i_reset_n    clock, asynchronous active-low reset
//   i_stb               request strobe, sampled only while idle
//   o_busy              high while a request is in progress
//   o_ack               one-cycle pulse when a request completes
//   i_digit, i_segment  digit index and data for a digit write
//   i_write_config      1 = configuration sequence, 0 = digit write
//   i_decode_mode, i_intensity, i_scan_limit, i_enable, i_display_test
//                       configuration register values
//   i_next              driver ack: current transfer finished
//   o_write             one-cycle strobe to driver
//   o_addr, o_data      register address/data to driver
// ---------------------------------------------------------------------------
module max7219_settings_ctrl
  import max7219_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_stb,
  output logic       o_busy,
  output logic       o_ack,
  input  logic [2:0] i_digit,
  input  logic [7:0] i_segment,
  input  logic       i_write_config,
  input  logic [7:0] i_decode_mode,
  input  logic [3:0] i_intensity,
  input  logic [2:0] i_scan_limit,
  input  logic       i_enable,
  input  logic       i_display_test,
  input  logic       i_next,
  output logic       o_write,
  output logic [3:0] o_addr,
  output logic [7:0] o_data
);

  state_e     state_q, state_d;
  req_t       req_q,   req_d;
  logic [2:0] idx_q,   idx_d;
  logic       busy_q,  busy_d;
  logic       ack_q,   ack_d;
  logic       write_q, write_d;
  logic [3:0] addr_q,  addr_d;
  logic [7:0] data_q,  data_d;

  req_t req_in;
  cmd_t accept_cmd;
  cmd_t next_cmd;

  assign req_in = '{
    write_config: i_write_config,
    digit:        i_digit,
    segment:      i_segment,
    decode_mode:  i_decode_mode,
    intensity:    i_intensity,
    scan_limit:   i_scan_limit,
    enable:       i_enable,
    display_test: i_display_test
  };

  // Outputs are registered, so the entry to present in ISSUE is looked up one
  // cycle early: from the live inputs on acceptance, from the latched request
  // when advancing out of WAIT.
  assign accept_cmd = cmd_entry(req_in, 3'd0);
  assign next_cmd   = cmd_entry(req_q, idx_q + 3'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_stb) begin
          req_d   = req_in;
          idx_d   = 3'd0;
          addr_d  = accept_cmd.addr;
          data_d  = accept_cmd.data;
          write_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_next) begin
          if (is_last(req_q, idx_q)) begin
            busy_d  = 1'b0;
            ack_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            addr_d  = next_cmd.addr;
            data_d  = next_cmd.data;
            write_d = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      idx_q   <= 3'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 4'h0;
      data_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_ack   = ack_q;
  assign o_write = write_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_max7219_settings_ctrl.sv
// ---------------------------------------------------------------------------
// tb_max7219_settings_ctrl
// Scoreboard bench: each request pushes its expected driver transactions into
// a queue; a monitor pops and compares whenever o_write is seen, checks that
// o_addr/o_data hold steady while busy, and accounts for every o_ack. A small
// driver model answers each o_write with an i_next pulse after a fixed delay.
// ---------------------------------------------------------------------------
module tb_max7219_settings_ctrl;

  localparam int DRV_LAT = 8;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } xfer_t;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_stb;
  logic       o_busy;
  logic       o_ack;
  logic [2:0] i_digit;
  logic [7:0] i_segment;
  logic       i_write_config;
  logic [7:0] i_decode_mode;
  logic [3:0] i_intensity;
  logic [2:0] i_scan_limit;
  logic       i_enable;
  logic       i_display_test;
  logic       i_next;
  logic       o_write;
  logic [3:0] o_addr;
  logic [7:0] o_data;

  logic drv_next   = 1'b0;
  logic stray_next = 1'b0;
  assign i_next = drv_next | stray_next;

  int    errors       = 0;
  int    checks       = 0;
  int    pending_acks = 0;
  int    ack_count    = 0;
  int    wr_count     = 0;
  xfer_t exp_q[$];
  xfer_t cur;
  logic  have_cur     = 1'b0;

  max7219_settings_ctrl dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_stb          (i_stb),
    .o_busy         (o_busy),
    .o_ack          (o_ack),
    .i_digit        (i_digit),
    .i_segment      (i_segment),
    .i_write_config (i_write_config),
    .i_decode_mode  (i_decode_mode),
    .i_intensity    (i_intensity),
    .i_scan_limit   (i_scan_limit),
    .i_enable       (i_enable),
    .i_display_test (i_display_test),
    .i_next         (i_next),
    .o_write        (o_write),
    .o_addr         (o_addr),
    .o_data         (o_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver model: answers each o_write with a one-cycle i_next DRV_LAT cycles later
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_write && i_reset_n) begin
        repeat (DRV_LAT) @(posedge i_clk);
        #1 drv_next = 1'b1;
        @(posedge i_clk);
        #1 drv_next = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_write) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: got addr 0x%0h data 0x%0h, no transfer expected", o_addr, o_data);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("xfer_addr", 32'(o_addr), 32'(cur.addr));
          check("xfer_data", 32'(o_data), 32'(cur.data));
        end
      end else if (o_busy && have_cur) begin
        check("hold_addr", 32'(o_addr), 32'(cur.addr));
        check("hold_data", 32'(o_data), 32'(cur.data));
      end
      if (o_ack) begin
        ack_count++;
        check("ack_busy_low", 32'(o_busy), 32'd0);
        if (pending_acks == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack: got ack with %0d requests outstanding", pending_acks);
        end else begin
          pending_acks--;
        end
      end
    end
  end

  // Issue a request; inputs applied now, strobe dropped just after the next edge
  task automatic do_req(input logic cfg, input logic [2:0] dig, input logic [7:0] seg,
                        input logic [7:0] dec, input logic [3:0] inten,
                        input logic [2:0] scan, input logic en, input logic tst);
    i_write_config = cfg;
    i_digit        = dig;
    i_segment      = seg;
    i_decode_mode  = dec;
    i_intensity    = inten;
    i_scan_limit   = scan;
    i_enable       = en;
    i_display_test = tst;
    i_stb          = 1'b1;
    if (cfg) begin
      exp_q.push_back('{addr: 4'h9, data: dec});
      exp_q.push_back('{addr: 4'hA, data: {4'h0, inten}});
      exp_q.push_back('{addr: 4'hB, data: {5'h00, scan}});
      exp_q.push_back('{addr: 4'hC, data: {7'h00, en}});
      exp_q.push_back('{addr: 4'hF, data: {7'h00, tst}});
    end else begin
      exp_q.push_back('{addr: 4'(dig) + 4'h1, data: seg});
    end
    pending_acks++;
    @(posedge i_clk);
    #1 i_stb = 1'b0;
  endtask

  // Returns at the negedge where o_ack is seen, or after the budget expires
  task automatic wait_done(input int budget, input string name);
    int  n    = 0;
    logic done = 1'b0;
    while (!done && n < budget) begin
      @(negedge i_clk);
      n++;
      if (o_ack) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: no ack after %0d cycles, required under %0d", name, n, budget);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    i_reset_n = 1'b0;
    i_stb = 1'b0; i_digit = '0; i_segment = '0; i_write_config = 1'b0;
    i_decode_mode = '0; i_intensity = '0; i_scan_limit = '0;
    i_enable = 1'b0; i_display_test = 1'b0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_ack",   32'(o_ack),   32'd0);
    check("rst_write", 32'(o_write), 32'd0);
    check("rst_addr",  32'(o_addr),  32'd0);
    check("rst_data",  32'(o_data),  32'd0);

    // i_next while idle is ignored
    @(posedge i_clk); #1 stray_next = 1'b1;
    @(posedge i_clk); #1 stray_next = 1'b0;
    @(negedge i_clk);
    check("idle_next_busy",  32'(o_busy),  32'd0);
    check("idle_next_write", 32'(o_write), 32'd0);

    // Configuration sequence
    @(posedge i_clk); #1;
    do_req(1'b1, 3'd0, 8'h00, 8'h0F, 4'd7, 3'd5, 1'b1, 1'b0);
    wait_done(160, "cfg_done");

    // Single digit write
    @(posedge i_clk); #1;
    do_req(1'b0, 3'd0, 8'h0F, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
    wait_done(64, "digit0_done");

    // Back-to-back digit writes, each new strobe on the previous ack cycle
    @(posedge i_clk); #1;
    do_req(1'b0, 3'd1, 8'h07, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
    wait_done(64, "digit1_done");
    do_req(1'b0, 3'd2, 8'h05, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
    wait_done(64, "digit2_done");
    do_req(1'b0, 3'd3, 8'h01, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
    wait_done(64, "digit3_done");

    // Strobe held until busy, inputs changed mid-transfer
    @(posedge i_clk); #1;
    i_write_config = 1'b0; i_digit = 3'd4; i_segment = 8'h3C; i_stb = 1'b1;
    exp_q.push_back('{addr: 4'h5, data: 8'h3C});
    pending_acks++;
    n = 0;
    while (!o_busy && n < 10) begin
      @(posedge i_clk); #1; n++;
    end
    check("hold_stb_busy", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_stb = 1'b0; i_digit = 3'd6; i_segment = 8'hFF;
    wait_done(64, "hold_done");
    repeat (5) @(negedge i_clk);
    check("hold_single_xfer", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a configuration sequence
    @(posedge i_clk); #1;
    base = wr_count;
    do_req(1'b1, 3'd0, 8'h00, 8'hFF, 4'hF, 3'd7, 1'b0, 1'b1);
    n = 0;
    while (wr_count < base + 2 && n < 100) begin
      @(negedge i_clk); n++;
    end
    check("mid_reset_reached", 32'(wr_count - base), 32'd2);
    repeat (4) @(posedge i_clk);
    #1 i_reset_n = 1'b0;
    exp_q.delete();
    pending_acks = 0;
    have_cur = 1'b0;
    #1;
    check("abort_busy",  32'(o_busy),  32'd0);
    check("abort_ack",   32'(o_ack),   32'd0);
    check("abort_write", 32'(o_write), 32'd0);
    check("abort_addr",  32'(o_addr),  32'd0);
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    repeat (20) @(posedge i_clk);
    check("abort_no_ack", 32'(ack_count), 32'd6);

    // Normal request after the abort, highest digit index
    #1;
    do_req(1'b0, 3'd7, 8'hA5, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
    wait_done(64, "post_reset_done");

    repeat (5) @(negedge i_clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_pending_acks", 32'(pending_acks), 32'd0);
    check("final_ack_count", 32'(ack_count), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max7219_settings_ctrl.md
Name: max7219_settings_ctrl

Overview:
- Sequencer between the clock/display logic and the MAX7219 serial driver (`max7219`).
- On a strobe it does one of two things:
  - Writes one digit register.
  - Writes the full configuration set: decode mode, intensity, scan limit, shutdown, display test.
- Each register write is issued as an addr/data transaction to the driver; the block waits for the driver's completion ack before moving on.

Parameters:
- None. Register addresses are fixed constants.

Ports:
- i_clk  in  1  system clock (~50 MHz)
- i_reset_n  in  1  reset, asynchronous, active-low
- i_stb  in  1  request; sampled only while idle
- o_busy  out  1  high while a request is in progress
- o_ack  out  1  one-cycle pulse when a request completes
- i_digit  in  3  digit index 0..7
- i_segment  in  8  digit data (BCD code or raw segments)
- i_write_config  in  1  1 = configuration sequence, 0 = digit write
- i_decode_mode  in  8  decode-mode register value
- i_intensity  in  4  intensity 0..15
- i_scan_limit  in  3  scan limit 0..7
- i_enable  in  1  1 = display on (shutdown register = 1)
- i_display_test  in  1  1 = display test on
- i_next  in  1  driver ack pulse: current transfer finished
- o_write  out  1  one-cycle strobe to driver
- o_addr  out  4  register address to driver
- o_data  out  8  register data to driver

Behaviour:
- Reset (async, i_reset_n=0):
  - State IDLE.
  - o_busy=0, o_ack=0, o_write=0, o_addr=0, o_data=0.
  - All latched inputs cleared.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - o_busy=0.
  - If i_stb=1, latch all inputs and i_write_config, then go to ISSUE.
  - o_busy is high from the next cycle.
- Command list for a digit write:
  - Single entry: addr = {1'b0, i_digit} + 1 (0x1..0x8), data = i_segment.
- Command list for a config write (order fixed):
  - 0x9 = decode_mode
  - 0xA = {4'h0, intensity}
  - 0xB = {5'h0, scan_limit}
  - 0xC = {7'h0, enable}
  - 0xF = {7'h0, display_test}
- ISSUE:
  - Drive o_addr/o_data for the current entry.
  - o_write=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold o_addr/o_data stable.
  - On i_next=1: if more entries remain, advance the index and go to ISSUE; otherwise go to IDLE.
- Completion:
  - On the cycle IDLE is re-entered, o_busy=0 and o_ack=1 together, for one cycle.
  - o_ack=0 at all other times.
- o_addr/o_data:
  - Constant for the entire duration of a digit write while o_busy=1.
  - Retain their last values in IDLE.
- Input changes while busy are ignored, because values were latched at acceptance.
- i_stb held high after acceptance does not retrigger while busy.
- i_stb asserted on the ack cycle is accepted; a new request then starts the following cycle.
- i_next outside WAIT is ignored.
- Reset mid-sequence aborts immediately to IDLE; no ack is produced.
- Timing budget (with `max7219` driver, ~32 cycles per transfer):
  - Digit write completes in under 64 cycles.
  - Config write completes in under 160 cycles.

Decomposition:
- Shared package max7219_pkg holds:
  - Register address constants: DIGIT0=0x1, DECODE=0x9, INTENSITY=0xA, SCAN_LIMIT=0xB, SHUTDOWN=0xC, TEST=0xF.
  - State enum.
  - Config entry count (5).
- No sub-module needed; the command list is a combinational mux indexed by a 3-bit counter.
- Pair with the existing `max7219` driver at top level: o_write→i_stb, i_next←o_ack, o_addr→i_addr, o_data→i_data.

Test Plan:
- Reset held 2 cycles, then released -> o_busy=0, o_ack=0, o_write=0, o_addr=0, o_data=0.
- Config write with decode=0x0F, intensity=7, scan_limit=5, enable=1, test=0 -> driver sees five transfers in order: 0x9/0x0F, 0xA/0x07, 0xB/0x05, 0xC/0x01, 0xF/0x00. o_busy falls within 160 cycles with o_ack=1 on that cycle.
- Digit write, digit=0, segment=0x0F -> single transfer 0x1/0x0F. o_addr/o_data stable every busy cycle; done within 64 cycles with o_ack.
- Digit writes (1,0x07), (2,0x05), (3,0x01) back-to-back -> addresses 0x2, 0x3, 0x4 with matching data, one ack each.
- i_stb held high until o_busy rises; i_digit/i_segment changed mid-transfer -> exactly one transfer with the originally latched values.
- Reset asserted during config sequence (after 2nd transfer) -> o_busy=0 immediately, no o_ack. Next request runs normally.
